mem_ctrl: RTL
=============

# mem_ctrl

Memory controller that services the load/store buffer's word-level data requests and the instruction fetcher's word reads over the single byte-wide RAM/IO port. Requests arrive as one-cycle pulses. Each request is serialised into 1–4 byte accesses, and completion is reported with a one-cycle done pulse carrying assembled read data. It sits between LSB/IFetch and the top-level RAM bus.

## Interface
- `ADDR_W`, default 32: address width.
- `IO_SEL_BIT`, default 17: when `addr[17:16]==2'b11` the access targets IO space.
- `clk` in, 1: clock.
- `rst` in, 1: reset, active-low, asynchronous.
- `rdy` in, 1: global ready; when low, all registers hold.
- `rollback` in, 1: mispredict flush.
- `mc_en` in, 1: data request pulse from LSB.
- `mc_wr` in, 1: 1 = store.
- `mc_pc` in, 32: byte address.
- `mc_len` in, 3: byte count, one of 1, 2 or 4.
- `mc_w_data` in, 32: store data, little-endian, low `mc_len` bytes used.
- `mc_done` out, 1: data request complete, one-cycle pulse.
- `mc_r_data` out, 32: load result, zero-extended; valid with `mc_done`.
- `if_en` in, 1: instruction read pulse, always 4 bytes.
- `if_pc` in, 32: fetch address.
- `if_done` out, 1: fetch complete pulse.
- `if_data` out, 32: fetched word.
- `mem_din` in, 8: RAM read byte.
- `mem_dout` out, 8: RAM write byte.
- `mem_a` out, 32: RAM byte address.
- `mem_wr` out, 1: 1 = write.
- `io_buffer_full` in, 1: UART FIFO full.

## Operation
- Reset values: state IDLE; both pending slots empty; `mc_done`, `if_done`, `mem_wr` = 0; `mem_a`, `mem_dout`, `mc_r_data`, `if_data` = 0.
- Each port has a pending slot that latches `{wr, addr, len, wdata}` on its enable pulse, including while the controller is busy. A pulse arriving while the same slot is already full is a protocol violation; the bench checks for it.
- Arbitration in IDLE: the data slot wins over the fetch slot. There is no preemption once a transaction has started.
- States:
  - IDLE: transitions to READ or WRITE on a selected slot.
  - READ / WRITE: byte counter `k` runs from 0 to len-1.
  - Return to IDLE on completion.
- READ: `mem_a` = addr+k with `mem_wr`=0. The byte returned for `k` is written to bits [8k+7:8k]; unused upper bytes are 0. Sign extension is performed by the consumer.
- WRITE: `mem_a` = addr+k, `mem_dout` = wdata byte k, `mem_wr`=1.
- IO stall: if the address is in IO space and `io_buffer_full`=1, drive `mem_wr`=0 and hold `k` for that cycle.
- Stores never come from the fetch port.
- `rollback`:
  - Abort any in-progress READ with no done pulse, and return to IDLE next edge.
  - Clear the fetch slot and any pending data read.
  - An in-progress or pending WRITE always completes and pulses `mc_done`, because committed stores survive a flush.
- A request pulse coincident with `rollback` is accepted, because it belongs to the post-flush stream.

## Timing
- E0 is the edge at which the request leaves IDLE. Outputs are registered.
- READ, length L:
  - byte k address is visible after edge Ek;
  - byte k data is captured at edge E(k+2);
  - done is high for the cycle after E(L+1).
  - LW therefore completes in 5 cycles from E0; LB in 2.
- WRITE, length L: byte k is written by the RAM at E(k+1); done is high the cycle after E(L), excluding IO stall cycles.
- The done pulse lasts exactly one cycle. Data is valid only while done is high.
- Back-to-back: the next transaction may start at the edge following the done-setting edge. One IDLE cycle always separates transactions.
- `rdy`=0 freezes state, counter, slots and outputs. Done pulses are stretched by the stall.
- Address arithmetic is 32-bit wrapping. No alignment requirement.
- Reset asserted mid-transaction drops everything immediately. The partial store is not completed.

## Structure
- Shared package contents:
  - state encoding IDLE/READ/WRITE;
  - `IO_SEL_BIT` and the IO-region match constant;
  - a `mem_req_t`-style bundle `{wr, addr[31:0], len[2:0], wdata[31:0]}`;
  - the byte-lane helper.
- One natural sub-module, `mem_req_slot`: a pending-request holder with set, clear and take, instantiated once per port.
- The FSM, counter and byte assembler stay in `mem_ctrl`.

## Test plan
- LW at 0x100 with RAM bytes 11 22 33 44 → `mc_done` is high for one cycle, 5 cycles after E0, with `mc_r_data`=0x44332211.
- SH of 0xABCD1234 to 0x200 → `mem_wr` at 0x200=0x34 and 0x201=0x12. `mc_done` is high 2 cycles after E0. 0x202 is untouched.
- `if_en` and `mc_en` pulse together → the data read is served first, then the fetch. Each gets one done pulse with correct data.
- SB to 0x30000 with `io_buffer_full` held high for 3 cycles → there are 3 stall cycles with `mem_wr`=0, then one write of the byte. `mc_done` arrives 3 cycles late.
- `rollback` during the 2nd byte of an LW → no `mc_done`. A new LB issued the next cycle returns correct data after 2 cycles.
- `rollback` during a committed SW → all 4 bytes are written and `mc_done` fires. The pending fetch is discarded, so no `if_done` follows.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding, IO-region
// decode constants, the pending-request bundle and byte-lane helpers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  // Default position of the two-bit IO-space selector in the byte address.
  localparam int unsigned IO_SEL_BIT_DEFAULT = 17;
  // Selector value that marks an IO-space access.
  localparam logic [1:0]  IO_MATCH           = 2'b11;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
  } mem_req_t;

  // Return w with byte lane `lane` replaced by b (little-endian lanes).
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Extract byte lane `lane` of w.
  function automatic logic [7:0] get_byte(input logic [31:0] w,
                                          input logic [1:0]  lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// Pending-request holder for one requester port.
//   set/set_req : latch a new request (wins over clr/take in the same cycle)
//   clr         : discard the held request (flush)
//   take        : the FSM has accepted the held request
//   valid/req   : slot occupancy and contents
// All state holds while rdy is low.
module mem_req_slot
  import mem_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     set,
  input  mem_req_t set_req,
  input  logic     clr,
  input  logic     take,
  output logic     valid,
  output mem_req_t req
);

  logic     valid_q, valid_d;
  mem_req_t req_q, req_d;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (clr || take) valid_d = 1'b0;
    // A request arriving alongside a flush belongs to the post-flush stream.
    if (set) begin
      valid_d = 1'b1;
      req_d   = set_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (rdy) begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid = valid_q;
  assign req   = req_q;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller. Serves word-level data requests (LSB) and
// instruction fetches over one byte-wide RAM/IO port.
//   rdy            : global enable, everything holds while low
//   rollback       : flush; aborts reads, lets committed stores finish
//   mc_*           : data request in, done pulse + zero-extended load data out
//   if_*           : 4-byte fetch request in, done pulse + word out
//   mem_*          : registered RAM bus (synchronous read, one-cycle latency)
//   io_buffer_full : stalls IO-space writes
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IO_SEL_BIT = IO_SEL_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              mc_en,
  input  logic              mc_wr,
  input  logic [ADDR_W-1:0] mc_pc,
  input  logic [2:0]        mc_len,
  input  logic [31:0]       mc_w_data,
  output logic              mc_done,
  output logic [31:0]       mc_r_data,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  function automatic logic is_io(input logic [31:0] a);
    return a[IO_SEL_BIT -: 2] == IO_MATCH;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  mem_req_t          cur_q, cur_d;
  logic              cur_if_q, cur_if_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mc_done_q, mc_done_d;
  logic [31:0]       mc_r_data_q, mc_r_data_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_data_q, if_data_d;

  logic     d_valid, f_valid, d_take, f_take, d_clr, f_clr;
  mem_req_t d_req, f_req, d_set_req, f_set_req;

  mem_req_t   wr_src;
  logic [2:0] wr_k;
  logic       wr_go;
  logic [2:0] cnt_nxt;
  logic [1:0] rd_lane;

  assign d_set_req = '{wr: mc_wr, addr: mc_pc, len: mc_len, wdata: mc_w_data};
  assign f_set_req = '{wr: 1'b0, addr: if_pc, len: 3'd4, wdata: '0};

  // Committed stores survive a flush; only reads are discarded.
  assign d_clr = rollback && !d_req.wr;
  assign f_clr = rollback;

  assign cnt_nxt = cnt_q + 3'd1;
  // In READ, cnt_q counts edges since E0; the byte landing now is cnt_q-1.
  assign rd_lane = 2'(cnt_q - 3'd1);

  mem_req_slot u_dslot (
    .clk(clk), .rst(rst), .rdy(rdy),
    .set(mc_en), .set_req(d_set_req), .clr(d_clr), .take(d_take),
    .valid(d_valid), .req(d_req)
  );

  mem_req_slot u_fslot (
    .clk(clk), .rst(rst), .rdy(rdy),
    .set(if_en), .set_req(f_set_req), .clr(f_clr), .take(f_take),
    .valid(f_valid), .req(f_req)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    cur_if_d    = cur_if_q;
    rbuf_d      = rbuf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    mc_done_d   = 1'b0;
    mc_r_data_d = mc_r_data_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    d_take      = 1'b0;
    f_take      = 1'b0;
    wr_go       = 1'b0;
    wr_src      = cur_q;
    wr_k        = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (d_valid && !d_clr) begin
          d_take   = 1'b1;
          cur_d    = d_req;
          cur_if_d = 1'b0;
        end else if (f_valid && !rollback) begin
          f_take   = 1'b1;
          cur_d    = f_req;
          cur_if_d = 1'b1;
        end
        if (d_take || f_take) begin
          rbuf_d = '0;
          if (cur_d.wr) begin
            state_d = ST_WRITE;
            wr_go   = 1'b1;
            wr_src  = cur_d;
            wr_k    = 3'd0;
          end else begin
            state_d = ST_READ;
            mem_a_d = cur_d.addr;
            cnt_d   = 3'd0;
          end
        end
      end

      ST_READ: begin
        if (rollback) begin
          state_d = ST_IDLE;
        end else begin
          if (cnt_q != 3'd0) rbuf_d = put_byte(rbuf_q, rd_lane, mem_din);
          if (cnt_q == cur_q.len) begin
            state_d = ST_IDLE;
            if (cur_if_q) begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end else begin
              mc_done_d   = 1'b1;
              mc_r_data_d = rbuf_d;
            end
          end else begin
            cnt_d = cnt_nxt;
            if (cnt_nxt < cur_q.len) mem_a_d = cur_q.addr + 32'(cnt_nxt);
          end
        end
      end

      ST_WRITE: begin
        if (cnt_q == cur_q.len) begin
          state_d   = ST_IDLE;
          mc_done_d = 1'b1;
        end else begin
          wr_go = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Shared byte-issue path for the first store byte (from IDLE) and the rest.
    if (wr_go) begin
      if (is_io(wr_src.addr) && io_buffer_full) begin
        cnt_d = wr_k;
      end else begin
        mem_a_d    = wr_src.addr + 32'(wr_k);
        mem_dout_d = get_byte(wr_src.wdata, wr_k[1:0]);
        mem_wr_d   = 1'b1;
        cnt_d      = wr_k + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      cur_if_q    <= 1'b0;
      rbuf_q      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      mc_done_q   <= 1'b0;
      mc_r_data_q <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      cur_if_q    <= cur_if_d;
      rbuf_q      <= rbuf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      mc_done_q   <= mc_done_d;
      mc_r_data_q <= mc_r_data_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign mc_done   = mc_done_q;
  assign mc_r_data = mc_r_data_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;

endmodule
